// File: rtl/buffer_fifo_pkg.sv
// rtl/buffer_fifo_pkg.sv - shared sizing helpers for the buffer FIFO slice
`ifndef BUFFER_FIFO_PKG_SV
`define BUFFER_FIFO_PKG_SV
package buffer_fifo_pkg;

    // Ceiling log2; sizes the pointers and the count port
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`endif

// File: rtl/buffer_fifo_wrap_counter.sv
// rtl/buffer_fifo_wrap_counter.sv - modulo-2^width pointer used for both FIFO ends
module wrap_counter #(
    parameter int width = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    output logic [width-1:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (increment) begin
            value <= value + width'(1);
        end
    end

endmodule

// File: rtl/buffer_fifo.sv
// rtl/buffer_fifo.sv - first-word-fall-through circular FIFO with sticky error flags
module buffer_fifo
    import buffer_fifo_pkg::*;
#(
    parameter int bitwidth = 8,
    parameter int depth    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_enable,
    input  logic [bitwidth-1:0]     value_in,
    input  logic                    read_enable,
    output logic [bitwidth-1:0]     value_out,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(depth):0]   count,
    input  logic                    clear_flags,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int aw = clog2(depth);

    logic [bitwidth-1:0] mem [depth];
    logic [aw-1:0]       wr_ptr;
    logic [aw-1:0]       rd_ptr;
    logic                wr_acc;
    logic                rd_acc;

    // A read frees a slot on the same edge, so a full FIFO still takes a write alongside it
    assign wr_acc = load_enable && (!full || read_enable);
    assign rd_acc = read_enable && !empty;

    wrap_counter #(.width(aw)) u_wr_ptr (
        .clock     (clock),
        .reset     (reset),
        .increment (wr_acc),
        .value     (wr_ptr)
    );

    wrap_counter #(.width(aw)) u_rd_ptr (
        .clock     (clock),
        .reset     (reset),
        .increment (rd_acc),
        .value     (rd_ptr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + (aw + 1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count <= count - (aw + 1)'(1);
        end
    end

    assign empty = (count == '0);
    assign full  = (count == (aw + 1)'(depth));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wr_ptr] <= value_in;
        end
    end

    assign value_out = empty ? '0 : mem[rd_ptr];

    // A fresh error event outranks a clear in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (load_enable && full && !read_enable) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (read_enable && empty) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_buffer_fifo.sv
// tb/tb_buffer_fifo.sv - self-checking bench for buffer_fifo against a queue model
module tb_buffer_fifo;

    localparam int W = 8;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         load_enable = 1'b0;
    logic [W-1:0] value_in = '0;
    logic         read_enable = 1'b0;
    logic         clear_flags = 1'b0;
    logic [W-1:0] value_out;
    logic         empty;
    logic         full;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    int vectors = 0;
    int errors  = 0;
    bit check_en = 1'b0;

    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    buffer_fifo #(.bitwidth(W), .depth(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_enable (load_enable),
        .value_in    (value_in),
        .read_enable (read_enable),
        .value_out   (value_out),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .clear_flags (clear_flags),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue of stored words plus two sticky bits
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit do_wr;
            bit do_rd;
            bit ovf_ev;
            bit udf_ev;
            do_wr  = load_enable && (mq.size() < D || read_enable);
            do_rd  = read_enable && mq.size() > 0;
            ovf_ev = load_enable && !read_enable && mq.size() == D;
            udf_ev = read_enable && mq.size() == 0;
            if (do_rd) void'(mq.pop_front());
            if (do_wr) mq.push_back(value_in);
            if (ovf_ev) m_ovf = 1'b1; else if (clear_flags) m_ovf = 1'b0;
            if (udf_ev) m_udf = 1'b1; else if (clear_flags) m_udf = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            cmp("count", 32'(count), 32'(mq.size()));
            cmp("empty", 32'(empty), 32'(mq.size() == 0));
            cmp("full", 32'(full), 32'(mq.size() == D));
            cmp("value_out", 32'(value_out), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
            cmp("overflow", 32'(overflow), 32'(m_ovf));
            cmp("underflow", 32'(underflow), 32'(m_udf));
            cmp("count_bound", 32'(count <= 3'(D)), 32'h1);
        end
    end

    task automatic cycle(input bit le, input logic [W-1:0] v, input bit re, input bit cf);
        load_enable = le;
        value_in    = v;
        read_enable = re;
        clear_flags = cf;
        @(posedge clock);
        #2;
        load_enable = 1'b0;
        read_enable = 1'b0;
        clear_flags = 1'b0;
    endtask

    initial begin
        int wrote;
        #1 reset = 1'b1;
        #2;
        cmp("rst_count", 32'(count), 32'h0);
        cmp("rst_empty", 32'(empty), 32'h1);
        cmp("rst_full", 32'(full), 32'h0);
        cmp("rst_value_out", 32'(value_out), 32'h0);
        cmp("rst_flags", 32'({overflow, underflow}), 32'h0);
        @(posedge clock);
        #2 reset = 1'b0;
        check_en = 1'b1;

        // Three writes after reset; first edge after release must accept
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 0);
        cmp("w3_count", 32'(count), 32'h3);
        cmp("w3_head", 32'(value_out), 32'h11);
        cmp("w3_flags", 32'({empty, full}), 32'h0);
        repeat (3) cycle(0, 8'h00, 1, 0);

        // Fill, then overflow with no read
        for (int i = 0; i < 4; i++) cycle(1, 8'hA0 + 8'(i), 0, 0);
        cmp("fill_full", 32'(full), 32'h1);
        cycle(1, 8'hFF, 0, 0);
        cmp("ovf_flag", 32'(overflow), 32'h1);
        cmp("ovf_count", 32'(count), 32'h4);
        for (int i = 0; i < 4; i++) begin
            cmp("ovf_read", 32'(value_out), 32'hA0 + 32'(i));
            cycle(0, 8'h00, 1, 0);
        end
        cmp("drain_empty", 32'(empty), 32'h1);
        cmp("drain_value_out", 32'(value_out), 32'h0);
        cycle(0, 8'h00, 0, 1);
        cmp("ovf_cleared", 32'(overflow), 32'h0);

        // Full with simultaneous write and read
        for (int i = 0; i < 4; i++) cycle(1, 8'hA0 + 8'(i), 0, 0);
        cycle(1, 8'h55, 1, 0);
        cmp("rw_full_head", 32'(value_out), 32'hA1);
        cmp("rw_full_count", 32'(count), 32'h4);
        cmp("rw_full_no_ovf", 32'(overflow), 32'h0);
        repeat (3) cycle(0, 8'h00, 1, 0);
        cmp("rw_full_last", 32'(value_out), 32'h55);
        cycle(0, 8'h00, 1, 0);

        // Empty read with simultaneous write, then clear
        cycle(1, 8'h7E, 1, 0);
        cmp("udf_flag", 32'(underflow), 32'h1);
        cmp("udf_count", 32'(count), 32'h1);
        cmp("udf_head", 32'(value_out), 32'h7E);
        cycle(0, 8'h00, 0, 1);
        cmp("udf_cleared", 32'(underflow), 32'h0);
        cycle(0, 8'h00, 1, 0);

        // Random-gap stream of 10*depth words across many wraps
        wrote = 0;
        for (int cyc = 0; cyc < 2000 && wrote < 10 * D; cyc++) begin
            bit le;
            bit re;
            le = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 2) == 0);
            if (le && (mq.size() < D || re)) begin
                cycle(1, 8'h40 + 8'(wrote), re, 0);
                wrote++;
            end else begin
                cycle(le, 8'hEE, re, 0);
            end
        end
        cmp("stream_done", 32'(wrote), 32'(10 * D));
        for (int i = 0; i < 2 * D; i++) cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 0, 1);

        // Asynchronous reset between edges with two words stored
        cycle(1, 8'hC1, 0, 0);
        cycle(1, 8'hC2, 0, 0);
        cmp("pre_rst_count", 32'(count), 32'h2);
        #1 reset = 1'b1;
        #1;
        cmp("mid_rst_count", 32'(count), 32'h0);
        cmp("mid_rst_empty", 32'(empty), 32'h1);
        cmp("mid_rst_value_out", 32'(value_out), 32'h0);
        reset = 1'b0;
        cycle(1, 8'h99, 0, 0);
        cmp("post_rst_head", 32'(value_out), 32'h99);
        cmp("post_rst_count", 32'(count), 32'h1);
        cycle(0, 8'h00, 1, 0);
        cmp("post_rst_empty", 32'(empty), 32'h1);
        cmp("post_rst_value_out", 32'(value_out), 32'h0);

        @(negedge clock);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
